cache_mem_arbiter: RTL



---
 rtl/cache_mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter giving the I-cache and D-cache exclusive, one-line-at-a-time
// access to the shared memory line port; D wins a fresh tie.
module cache_mem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, I_MEM, D_MEM, I_DONE, D_DONE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} side_t;

  state_t state;
  side_t  last_grant;
  logic   d_req;
  logic   pick_d;

  assign d_req = d_read | d_write;
  // D wins when it is alone, or on a tie when I was served last.
  assign pick_d = d_req && (!i_read || (last_grant == GRANT_I));
  assign busy   = (state != IDLE) | i_read | d_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      i_rdata    <= '0;
      i_resp     <= 1'b0;
      d_rdata    <= '0;
      d_resp     <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            mem_addr   <= d_addr;
            last_grant <= GRANT_D;
            state      <= D_MEM;
            if (d_write) begin
              mem_wdata <= d_wdata;
              mem_write <= 1'b1;
            end else begin
              mem_read  <= 1'b1;
            end
          end else if (i_read) begin
            mem_addr   <= i_addr;
            mem_read   <= 1'b1;
            last_grant <= GRANT_I;
            state      <= I_MEM;
          end
        end
        I_MEM: begin
          if (mem_resp) begin
            i_rdata  <= mem_rdata;
            mem_read <= 1'b0;
            i_resp   <= 1'b1;
            state    <= I_DONE;
          end
        end
        D_MEM: begin
          if (mem_resp) begin
            if (mem_read) begin
              d_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_resp    <= 1'b1;
            state     <= D_DONE;
          end
        end
        I_DONE: begin
          i_resp <= 1'b0;
          state  <= IDLE;
        end
        D_DONE: begin
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          i_resp    <= 1'b0;
          d_resp    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
